// File: rtl/sle_pipe.sv
// WIDTH x DEPTH shift pipeline of SLE-style registers (async load, enable, sync load)
// with per-stage valid bits and occupancy count. Define SLE_PIPE_PARITY_EN for per-stage parity with sticky par_err.
module sle_pipe #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] ALOAD_VAL = '0,
  parameter logic [WIDTH-1:0] SLOAD_VAL = '0
) (
  input  logic                         clk,
  input  logic                         aln,
  input  logic                         en,
  input  logic                         sln,
  input  logic [WIDTH-1:0]             d,
  input  logic                         d_valid,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  output logic [WIDTH*DEPTH-1:0]       q_all,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         par_err
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [CW-1:0]               count_q, count_d;

  always_comb begin
    data_d  = data_q;
    vld_d   = vld_q;
    count_d = count_q;
    if (en) begin
      if (!sln) begin
        for (int unsigned k = 0; k < DEPTH; k++) data_d[k] = SLOAD_VAL;
        vld_d   = '0;
        count_d = '0;
      end else begin
        data_d[0] = d;
        vld_d[0]  = d_valid;
        for (int unsigned k = 1; k < DEPTH; k++) begin
          data_d[k] = data_q[k-1];
          vld_d[k]  = vld_q[k-1];
        end
        // count tracks popcount(vld); it cannot exceed DEPTH, so no wrap guard is needed
        count_d = count_q + CW'(d_valid) - CW'(vld_q[DEPTH-1]);
      end
    end
  end

  always_ff @(posedge clk or negedge aln) begin
    if (!aln) begin
      for (int unsigned k = 0; k < DEPTH; k++) data_q[k] <= ALOAD_VAL;
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

  assign q       = data_q[DEPTH-1];
  assign q_valid = vld_q[DEPTH-1];
  assign q_all   = data_q;
  assign count   = count_q;
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);

`ifdef SLE_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d;
  logic             par_err_q, par_err_d;

  always_comb begin
    par_d     = par_q;
    par_err_d = par_err_q;
    if (en) begin
      if (!sln) begin
        par_d     = {DEPTH{^SLOAD_VAL}};
        par_err_d = 1'b0;
      end else begin
        par_d[0] = ^d;
        for (int unsigned k = 1; k < DEPTH; k++) par_d[k] = par_q[k-1];
        // Checked on the word leaving the pipe, before it is overwritten
        if (vld_q[DEPTH-1] && ((^data_q[DEPTH-1]) != par_q[DEPTH-1])) par_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge aln) begin
    if (!aln) begin
      par_q     <= {DEPTH{^ALOAD_VAL}};
      par_err_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sle_pipe.sv
// Scoreboard bench for sle_pipe (WIDTH=8, DEPTH=4, SLOAD_VAL=A5): directed steps push
// hand-computed expectations; a monitor pops and compares after each clock edge or async load.
module tb_sle_pipe;

`ifdef SLE_PIPE_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        aln = 1'b1;
  logic        en = 1'b0;
  logic        sln = 1'b1;
  logic [7:0]  d = '0;
  logic        d_valid = 1'b0;
  logic [7:0]  q;
  logic        q_valid;
  logic [31:0] q_all;
  logic [2:0]  count;
  logic        full, empty, par_err;

  sle_pipe #(.WIDTH(8), .DEPTH(4), .ALOAD_VAL(8'h00), .SLOAD_VAL(8'hA5)) dut (
    .clk(clk), .aln(aln), .en(en), .sln(sln), .d(d), .d_valid(d_valid),
    .q(q), .q_valid(q_valid), .q_all(q_all), .count(count),
    .full(full), .empty(empty), .par_err(par_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  q;
    logic        qv;
    logic [2:0]  cnt;
    logic [31:0] all;
    logic        pe;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   nobs   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s obs %0d: got %h expected %h", name, nobs, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or negedge aln);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        nobs++;
        chk("q",       32'(q),       32'(e.q));
        chk("q_valid", 32'(q_valid), 32'(e.qv));
        chk("count",   32'(count),   32'(e.cnt));
        chk("full",    32'(full),    32'(e.cnt == 3'd4));
        chk("empty",   32'(empty),   32'(e.cnt == 3'd0));
        chk("q_all",   q_all,        e.all);
        chk("par_err", 32'(par_err), 32'(e.pe));
      end
    end
  end

  task automatic push(input logic [7:0] eq, input logic eqv, input logic [2:0] ec,
                      input logic [31:0] ea, input logic epe);
    exp_t e;
    e.q = eq; e.qv = eqv; e.cnt = ec; e.all = ea; e.pe = epe;
    sb.push_back(e);
  endtask

  task automatic step(input logic s_en, input logic s_sln, input logic [7:0] s_d, input logic s_dv,
                      input logic [7:0] eq, input logic eqv, input logic [2:0] ec,
                      input logic [31:0] ea, input logic epe);
    @(negedge clk);
    en = s_en; sln = s_sln; d = s_d; d_valid = s_dv;
    push(eq, eqv, ec, ea, epe);
  endtask

  task automatic aload_pulse();
    @(negedge clk);
    en = 1'b0; sln = 1'b1; d = 8'hFF; d_valid = 1'b1;
    #2;
    push(8'h00, 1'b0, 3'd0, 32'h0000_0000, 1'b0);
    aln = 1'b0;
    #2;
    aln = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    // Initial async load, observed without a clock edge
    #2;
    push(8'h00, 1'b0, 3'd0, 32'h0000_0000, 1'b0);
    aln = 1'b0;
    @(negedge clk);
    aln = 1'b1;

    // Fill and overflow-shift
    step(1, 1, 8'h11, 1, 8'h00, 0, 3'd1, 32'h0000_0011, 0);
    step(1, 1, 8'h22, 1, 8'h00, 0, 3'd2, 32'h0000_1122, 0);
    step(1, 1, 8'h33, 1, 8'h00, 0, 3'd3, 32'h0011_2233, 0);
    step(1, 1, 8'h44, 1, 8'h11, 1, 3'd4, 32'h1122_3344, 0);
    step(1, 1, 8'h55, 1, 8'h22, 1, 3'd4, 32'h2233_4455, 0);

    // Stall while d and sln toggle
    step(0, 0, 8'hEE, 1, 8'h22, 1, 3'd4, 32'h2233_4455, 0);
    step(0, 1, 8'h99, 0, 8'h22, 1, 3'd4, 32'h2233_4455, 0);
    step(0, 0, 8'h5A, 1, 8'h22, 1, 3'd4, 32'h2233_4455, 0);
    step(1, 1, 8'h66, 1, 8'h33, 1, 3'd4, 32'h3344_5566, 0);

    // Async load mid-stream, then first shift loads stage 0 only
    aload_pulse();
    step(1, 1, 8'h77, 1, 8'h00, 0, 3'd1, 32'h0000_0077, 0);

    // Sync load, then sync load request while disabled
    step(1, 0, 8'h12, 1, 8'hA5, 0, 3'd0, 32'hA5A5_A5A5, 0);
    step(0, 0, 8'h34, 1, 8'hA5, 0, 3'd0, 32'hA5A5_A5A5, 0);

    // Mixed valid pattern 1,0,1,1,0,0
    step(1, 1, 8'h01, 1, 8'hA5, 0, 3'd1, 32'hA5A5_A501, 0);
    step(1, 1, 8'h02, 0, 8'hA5, 0, 3'd1, 32'hA5A5_0102, 0);
    step(1, 1, 8'h03, 1, 8'hA5, 0, 3'd2, 32'hA501_0203, 0);
    step(1, 1, 8'h04, 1, 8'h01, 1, 3'd3, 32'h0102_0304, 0);
    step(1, 1, 8'h05, 0, 8'h02, 0, 3'd2, 32'h0203_0405, 0);
    step(1, 1, 8'h06, 0, 8'h03, 1, 3'd2, 32'h0304_0506, 0);

    // Corrupt valid word 04 in stage 2 (parity build only), then drain it through q
    @(posedge clk);
    #2;
`ifdef SLE_PIPE_PARITY_EN
    begin
      logic [31:0] tmp;
      tmp = dut.data_q;
      tmp[16] = ~tmp[16];
      force dut.data_q = tmp;
      #1;
      release dut.data_q;
    end
`endif
    step(1, 1, 8'h07, 0, PAR ? 8'h05 : 8'h04, 1, 3'd1,
         PAR ? 32'h0505_0607 : 32'h0405_0607, 0);
    step(1, 1, 8'h08, 0, 8'h05, 0, 3'd0, 32'h0506_0708, PAR);
    step(1, 1, 8'h09, 0, 8'h06, 0, 3'd0, 32'h0607_0809, PAR);
    step(0, 1, 8'h0A, 1, 8'h06, 0, 3'd0, 32'h0607_0809, PAR);
    step(1, 0, 8'h0B, 1, 8'hA5, 0, 3'd0, 32'hA5A5_A5A5, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sle_pipe.md
Name: sle_pipe

Overview:
Parametrised successor to the single-bit SLE storage element. Provides a WIDTH-bit, DEPTH-stage shift pipeline, where every stage is an SLE-style register with the same controls: async load, enable and active-low sync load. Adds per-stage valid tracking, an occupancy counter and full/empty flags. Used as a retiming/delay line between datapath blocks where a stall (en=0) must freeze all stages.

Parameters:
WIDTH, 8, data bits per stage (>=1)
DEPTH, 4, number of stages (>=1); latency in enabled cycles
ALOAD_VAL, 0, WIDTH-bit value forced into every stage on async load
SLOAD_VAL, 0, WIDTH-bit value written into every stage on sync load

Ports:
clk  input  1  rising-edge clock
aln  input  1  asynchronous active-low load (reset); the system releases it synchronously to clk
en  input  1  global enable; 0 = hold all state
sln  input  1  active-low synchronous load; effective only when en=1
d  input  WIDTH  data into stage 0
d_valid  input  1  d carries a valid word
q  output  WIDTH  data of stage DEPTH-1
q_valid  output  1  valid bit of stage DEPTH-1
q_all  output  WIDTH*DEPTH  all stage data; stage k at bits [k*WIDTH +: WIDTH]
count  output  $clog2(DEPTH+1)  number of valid words in the pipe, range 0..DEPTH
full  output  1  count==DEPTH
empty  output  1  count==0
par_err  output  1  sticky parity error (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on aln.
- aln=0, asynchronous and highest priority:
  - every stage <= ALOAD_VAL
  - all valid bits <= 0
  - count <= 0, par_err <= 0
  - Resulting outputs: q=ALOAD_VAL, q_valid=0, empty=1, full=0.
- Rising clk with aln=1 (priority order):
  - en=0: hold every stage, valid bit, count and par_err; d and d_valid are ignored.
  - en=1, sln=0 (sync load): every stage <= SLOAD_VAL, valid <= 0, count <= 0, par_err <= 0. d is discarded.
  - en=1, sln=1 (shift):
    - stage0 <= d, v0 <= d_valid
    - stage k <= stage k-1 and v k <= v k-1, for k = 1..DEPTH-1
    - count <= count + d_valid - v[DEPTH-1]; ranges 0..DEPTH, so it can never wrap.
- Invalid words still shift; their data is not forced to any value.
- Latency: a word presented at enabled edge N appears on q after edge N+DEPTH-1 (DEPTH enabled edges in total). Disabled cycles do not count toward latency.
- DEPTH=1: stage0 drives q directly; count is 0..1.
- full and empty are combinational decodes of the count register; there is no back-pressure. A full pipe keeps shifting and the oldest word leaves on q.
- aln asserted mid-operation: state clears immediately, without waiting for a clock edge. The first shift after release loads stage0 only.
- All outputs are registered or decoded from registers; there is no combinational path from d to q.

Optional Feature:
Macro SLE_PIPE_PARITY_EN.
- Defined:
  - Each stage carries an extra even-parity bit, computed from d at stage-0 entry.
  - The bit shifts, loads and holds with its stage. Async load and sync load write the parity of ALOAD_VAL and SLOAD_VAL respectively.
  - On any enabled shift edge where q_valid=1 and parity(q) does not match the stored bit, par_err <= 1.
  - par_err is sticky; it is cleared only by aln=0 or a sync load.
- Not defined: no parity storage; par_err is tied to 0.

Test Plan (WIDTH=8, DEPTH=4, ALOAD_VAL=8'h00, SLOAD_VAL=8'hA5):
1. Pulse aln=0 mid-stream between clock edges -> immediately q=8'h00, q_valid=0, count=0, empty=1; no clock edge needed.
2. en=1, sln=1, d=8'h11,22,33,44 with d_valid=1 on 4 edges -> q=8'h11 with q_valid=1 after the 4th edge; count=4, full=1. Fifth word 8'h55 -> q=8'h22, count stays 4.
3. Stall: with the pipe as in scenario 2, hold en=0 for 3 cycles while toggling d and sln -> q_all, count and q_valid unchanged. Re-enable -> shifting resumes from the held state.
4. Sync load: en=1, sln=0 on one edge -> all q_all bytes = 8'hA5, q_valid=0, count=0. Repeat with en=0, sln=0 -> no change.
5. Mixed valid: d_valid pattern 1,0,1,1,0,0 -> count sequence 1,1,2,3,2,2, matching the entering d_valid and departing v[3] on each edge.
6. Parity, with SLE_PIPE_PARITY_EN: force a bit flip in stage 2 data -> par_err=1 when the word reaches q with q_valid=1, stays 1 afterwards, and clears on sln=0. Without the macro -> par_err=0 throughout.
